spi_ram_master: RTL and testbench

//  Sequences transactions to the SPI RAM peripheral from the system clock domain.

---
 rtl/spi_ram_master.sv | 162 ++++++++++++++++
 tb/tb_spi_ram_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// spi_ram_master: runs one SPI RAM transaction at a time in mode 0, MSB first.
// Each transaction sends a read (03h) or write (02h) command, a 24-bit address
// and 1..2**LEN_BITS data bytes. spi_clk is derived from clk by a half-period divider.
module spi_ram_master #(
  parameter int CLK_DIV  = 2,
  parameter int LEN_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_write,
  input  logic [23:0]         addr,
  input  logic [LEN_BITS-1:0] len_m1,
  input  logic [7:0]          wr_data,
  output logic                wr_take,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                spi_clk,
  output logic                spi_mosi,
  output logic                spi_select,
  input  logic                spi_miso
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int CDW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW  = LEN_BITS + 6;
  localparam logic [CDW-1:0] DIV_LAST = CDW'(CLK_DIV - 1);

  state_t                state_q;
  logic [CDW-1:0]        div_q, div_d;
  logic                  tick;
  logic [CW-1:0]         bitIdx_q;
  logic [CW-1:0]         lastIdx;
  logic                  inData, byteEnd, isLast;
  logic [30:0]           shift_q;
  logic [6:0]            rxShift_q;
  logic                  isWrite_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [31:0]           cmdWord;

  logic spiClk_q, spiMosi_q, spiSelect_q;
  logic busy_q, done_q, wrTake_q, rdValid_q;
  logic [7:0] rdData_q;

  assign cmdWord = {(is_write ? 8'h02 : 8'h03), addr};

  // Half-period divider next value, tick strobe and bit-position decode
  always_comb begin
    tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    div_d   = ((state_q == IDLE) || tick) ? '0 : div_q + CDW'(1);
    lastIdx = CW'(39) + CW'({len_q, 3'b000});
    inData  = (bitIdx_q >= CW'(32));
    byteEnd = (bitIdx_q[2:0] == 3'd7);
    isLast  = (bitIdx_q == lastIdx);
  end

  // Divider counter: restarts whenever the sequencer is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Transaction sequencer with all SPI and host-side outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      rxShift_q   <= '0;
      isWrite_q   <= 1'b0;
      len_q       <= '0;
      spiClk_q    <= 1'b0;
      spiMosi_q   <= 1'b0;
      spiSelect_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrTake_q    <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      wrTake_q  <= 1'b0;
      rdValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            isWrite_q   <= is_write;
            len_q       <= len_m1;
            shift_q     <= cmdWord[30:0];
            spiMosi_q   <= cmdWord[31];
            bitIdx_q    <= '0;
            busy_q      <= 1'b1;
            spiSelect_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!spiClk_q) begin
              spiClk_q <= 1'b1;
              if (inData && !isWrite_q) begin
                rxShift_q <= {rxShift_q[5:0], spi_miso};
                if (byteEnd) begin
                  rdData_q  <= {rxShift_q, spi_miso};
                  rdValid_q <= 1'b1;
                end
              end
            end else begin
              spiClk_q <= 1'b0;
              bitIdx_q <= bitIdx_q + CW'(1);
              if (isLast) begin
                spiSelect_q <= 1'b1;
                spiMosi_q   <= 1'b0;
                state_q     <= HOLD;
              end else if (byteEnd && (bitIdx_q >= CW'(31))) begin
                if (isWrite_q) begin
                  shift_q   <= {wr_data[6:0], 24'h000000};
                  spiMosi_q <= wr_data[7];
                  wrTake_q  <= 1'b1;
                end else begin
                  shift_q   <= '0;
                  spiMosi_q <= 1'b0;
                end
              end else begin
                shift_q   <= {shift_q[29:0], 1'b0};
                spiMosi_q <= shift_q[30];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign spi_clk    = spiClk_q;
  assign spi_mosi   = spiMosi_q;
  assign spi_select = spiSelect_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_take    = wrTake_q;
  assign rd_valid   = rdValid_q;
  assign rd_data    = rdData_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with a behavioural SPI RAM peripheral
// per DUT instance. Instance 0 uses CLK_DIV=2, instance 1 uses CLK_DIV=1.
module tb_spi_ram_master;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  // Free-running system clock shared by both instances
  always #5 clk = ~clk;

  logic [1:0]   startV, isWrV;
  logic [23:0]  addrV [2];
  logic [2:0]   lenV [2];
  logic [7:0]   wrDataV [2];
  logic [1:0]   wrTakeV, rdValidV, busyV, doneV;
  logic [7:0]   rdDataV [2];
  logic [1:0]   sClk, sMosi, sSel, sMiso;
  logic [127:0] logV [2];
  int           logCntV [2];

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0]  wBytes [8];
  int          takes, valids, dones, cyclesToDone;
  logic        busyEarly, doneSeen, takeSeen;
  logic [63:0] rdPacked;

  spi_ram_master #(.CLK_DIV(2), .LEN_BITS(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .is_write(isWrV[0]),
    .addr(addrV[0]), .len_m1(lenV[0]), .wr_data(wrDataV[0]),
    .wr_take(wrTakeV[0]), .rd_data(rdDataV[0]), .rd_valid(rdValidV[0]),
    .busy(busyV[0]), .done(doneV[0]), .spi_clk(sClk[0]), .spi_mosi(sMosi[0]),
    .spi_select(sSel[0]), .spi_miso(sMiso[0])
  );

  spi_ram_master #(.CLK_DIV(1), .LEN_BITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .is_write(isWrV[1]),
    .addr(addrV[1]), .len_m1(lenV[1]), .wr_data(wrDataV[1]),
    .wr_take(wrTakeV[1]), .rd_data(rdDataV[1]), .rd_valid(rdValidV[1]),
    .busy(busyV[1]), .done(doneV[1]), .spi_clk(sClk[1]), .spi_mosi(sMosi[1]),
    .spi_select(sSel[1]), .spi_miso(sMiso[1])
  );

  // SPI RAM peripheral models: mode 0, 03h read / 02h write, aborts on select high
  for (genvar g = 0; g < 2; g++) begin : gPeriph
    logic [7:0]   mem [0:4095];
    logic         misoBit;
    logic [127:0] logBits;
    int           logCnt;

    assign sMiso[g]   = misoBit;
    assign logV[g]    = logBits;
    assign logCntV[g] = logCnt;

    // Serves one transaction per select-low window
    initial begin
      int bits;
      int txIdx;
      logic [31:0] cmdReg;
      logic [23:0] ptr;
      logic rdMode;
      logic [7:0] rxB, txB;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[0] = 8'h07; mem[1] = 8'h4B; mem[2] = 8'h08; mem[3] = 8'h4A;
      if (g == 1) begin
        mem[4] = 8'h5A; mem[5] = 8'hC3; mem[6] = 8'h0F; mem[7] = 8'hF0;
      end
      misoBit = 1'b0;
      logBits = '0;
      logCnt  = 0;
      forever begin
        @(negedge sSel[g]);
        bits = 0; txIdx = 0; cmdReg = '0; ptr = '0; rdMode = 1'b0;
        rxB = '0; txB = '0; logBits = '0; logCnt = 0; misoBit = 1'b0;
        while (sSel[g] == 1'b0) begin
          @(posedge sClk[g] or posedge sSel[g]);
          if (sSel[g]) break;
          bits++;
          rxB = {rxB[6:0], sMosi[g]};
          if (bits <= 32) cmdReg = {cmdReg[30:0], sMosi[g]};
          if (bits % 8 == 0) begin
            logBits = {logBits[119:0], rxB};
            logCnt++;
          end
          if (bits == 32) begin
            ptr    = cmdReg[23:0];
            rdMode = (cmdReg[31:24] == 8'h03);
            if (rdMode) begin
              txB = mem[ptr[11:0]];
              ptr = ptr + 24'd1;
            end
          end else if (bits > 32 && bits % 8 == 0 && cmdReg[31:24] == 8'h02) begin
            mem[ptr[11:0]] = rxB;
            ptr = ptr + 24'd1;
          end
          @(negedge sClk[g] or posedge sSel[g]);
          if (sSel[g]) break;
          if (rdMode) begin
            misoBit = txB[7 - txIdx];
            txIdx++;
            if (txIdx == 8) begin
              txIdx = 0;
              txB = mem[ptr[11:0]];
              ptr = ptr + 24'd1;
            end
          end
        end
        misoBit = 1'b0;
      end
    end
  end

  // Counts one comparison and reports it when the observed value differs
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one transaction on an instance and records its handshakes until done
  task automatic applyStimulus(input int inst, input logic w, input logic [23:0] a,
                               input logic [2:0] l, input int midStart);
    int wIdx;
    takes = 0; valids = 0; dones = 0; cyclesToDone = 0; rdPacked = '0;
    busyEarly = 1'b0; doneSeen = 1'b0; wIdx = 0;
    @(negedge clk);
    wrDataV[inst] = wBytes[0];
    isWrV[inst]   = w;
    addrV[inst]   = a;
    lenV[inst]    = l;
    startV[inst]  = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      startV[inst] = (k == midStart);
      if (k == midStart) addrV[inst] = 24'h000900;
      if (k == 1) busyEarly = busyV[inst];
      if (wrTakeV[inst]) begin
        takes++;
        if (wIdx < 7) wIdx++;
        wrDataV[inst] = wBytes[wIdx];
      end
      if (rdValidV[inst]) begin
        valids++;
        rdPacked = {rdPacked[55:0], rdDataV[inst]};
      end
      if (doneV[inst]) begin
        dones++;
        if (!doneSeen) begin
          doneSeen = 1'b1;
          cyclesToDone = k;
        end
      end
      if (doneSeen && k >= cyclesToDone + 20) break;
    end
    startV[inst] = 1'b0;
  endtask

  // Directed test sequence
  initial begin
    startV = '0; isWrV = '0;
    for (int i = 0; i < 2; i++) begin
      addrV[i] = '0; lenV[i] = '0; wrDataV[i] = '0;
    end
    for (int i = 0; i < 8; i++) wBytes[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_select", {63'd0, sSel[0]}, 64'd1);
    checkOutput("rst_spiclk", {63'd0, sClk[0]}, 64'd0);
    checkOutput("rst_mosi", {63'd0, sMosi[0]}, 64'd0);
    checkOutput("rst_busy", {63'd0, busyV[0]}, 64'd0);
    checkOutput("rst_done", {63'd0, doneV[0]}, 64'd0);
    checkOutput("rst_wrtake", {63'd0, wrTakeV[0]}, 64'd0);
    checkOutput("rst_rdvalid", {63'd0, rdValidV[0]}, 64'd0);
    checkOutput("rst_rddata", {56'd0, rdDataV[0]}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write A5h,3Ch to 000800h
    wBytes[0] = 8'hA5; wBytes[1] = 8'h3C; wBytes[2] = 8'h00;
    applyStimulus(0, 1'b1, 24'h000800, 3'd1, 0);
    checkOutput("wr_done_seen", {63'd0, doneSeen}, 64'd1);
    checkOutput("wr_latency", 64'(cyclesToDone), 64'd197);
    checkOutput("wr_busy_early", {63'd0, busyEarly}, 64'd1);
    checkOutput("wr_takes", 64'(takes), 64'd2);
    checkOutput("wr_no_rdvalid", 64'(valids), 64'd0);
    checkOutput("wr_done_count", 64'(dones), 64'd1);
    checkOutput("wr_mosi_bytes", 64'(logCntV[0]), 64'd6);
    checkOutput("wr_mosi_stream", {16'd0, logV[0][47:0]}, 64'h0000_0200_0800_A53C);

    // Read back 000800h
    applyStimulus(0, 1'b0, 24'h000800, 3'd1, 0);
    checkOutput("rd_latency", 64'(cyclesToDone), 64'd197);
    checkOutput("rd_valids", 64'(valids), 64'd2);
    checkOutput("rd_data", rdPacked, 64'h0000_0000_0000_A53C);
    checkOutput("rd_no_take", 64'(takes), 64'd0);
    checkOutput("rd_select_idle", {63'd0, sSel[0]}, 64'd1);
    checkOutput("rd_spiclk_idle", {63'd0, sClk[0]}, 64'd0);

    // ROM region read, 4 bytes
    applyStimulus(0, 1'b0, 24'h000000, 3'd3, 0);
    checkOutput("rom_valids", 64'(valids), 64'd4);
    checkOutput("rom_data", rdPacked, 64'h0000_0000_074B_084A);
    checkOutput("rom_latency", 64'(cyclesToDone), 64'd261);

    // start pulsed mid-transfer with another address must be ignored
    applyStimulus(0, 1'b0, 24'h000800, 3'd1, 50);
    checkOutput("mid_done_count", 64'(dones), 64'd1);
    checkOutput("mid_data", rdPacked, 64'h0000_0000_0000_A53C);
    checkOutput("mid_mosi_stream", {16'd0, logV[0][47:0]}, 64'h0000_0300_0800_0000);
    checkOutput("mid_latency", 64'(cyclesToDone), 64'd197);

    // Reset asserted during byte 0 of a write
    takeSeen = 1'b0;
    @(negedge clk);
    wrDataV[0] = 8'hFF; isWrV[0] = 1'b1; addrV[0] = 24'h000800; lenV[0] = 3'd1;
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (wrTakeV[0]) begin
        takeSeen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort_take_seen", {63'd0, takeSeen}, 64'd1);
    repeat (6) @(negedge clk);
    checkOutput("abort_pre_select", {63'd0, sSel[0]}, 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_select", {63'd0, sSel[0]}, 64'd1);
    checkOutput("abort_spiclk", {63'd0, sClk[0]}, 64'd0);
    checkOutput("abort_busy", {63'd0, busyV[0]}, 64'd0);
    checkOutput("abort_done", {63'd0, doneV[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(0, 1'b0, 24'h000800, 3'd1, 0);
    checkOutput("abort_readback", rdPacked, 64'h0000_0000_0000_A53C);

    // Eight-byte read with CLK_DIV=1
    applyStimulus(1, 1'b0, 24'h000000, 3'd7, 0);
    checkOutput("div1_valids", 64'(valids), 64'd8);
    checkOutput("div1_latency", 64'(cyclesToDone), 64'd195);
    checkOutput("div1_data", rdPacked, 64'h074B_084A_5AC3_0FF0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
